// File: rtl/axi_bm13xx_pkg.sv
// Shared BM13xx receive-path definitions: frame geometry, preamble bytes, CRC5 constants,
// collect/push FSM state types and the bit-serial CRC5 step.
package axi_bm13xx_pkg;

    localparam int unsigned FRAME_LEN_BM138X = 7;
    localparam int unsigned FRAME_LEN_BM139X = 9;

    localparam logic [7:0] PREAMBLE_0 = 8'hAA;
    localparam logic [7:0] PREAMBLE_1 = 8'h55;

    localparam logic [4:0] CRC5_POLY = 5'b00101;
    localparam logic [4:0] CRC5_INIT = 5'b11111;

    // Bit of B6 that selects work (1) or command (0) response
    localparam int unsigned TYPE_BIT = 7;

    typedef enum logic [1:0] {ColIdle, ColPre1, ColBody, ColCheck} col_state_e;
    typedef enum logic [1:0] {PushIdle, PushW0, PushW1} push_state_e;

    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
        logic fb;
        fb = crc[4] ^ din;
        return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    endfunction

endpackage

// File: rtl/bm13xx_work_rx_parser_if.sv
// Byte-stream input and the two RX FIFO write ports of the BM13xx response parser.
interface bm13xx_work_rx_parser_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] work_data;
    logic        work_wr;
    logic        work_afull;
    logic [31:0] cmd_data;
    logic        cmd_wr;
    logic        cmd_afull;

    modport master (
        input  rx_data, rx_valid, work_afull, cmd_afull,
        output work_data, work_wr, cmd_data, cmd_wr
    );

    modport slave (
        output rx_data, rx_valid, work_afull, cmd_afull,
        input  work_data, work_wr, cmd_data, cmd_wr
    );

endinterface

// File: rtl/bm13xx_crc5.sv
// Bytewise CRC5 (x^5+x^2+1) accumulator; last_i processes only data_i[7:5] for the final
// partial byte of a frame.
module bm13xx_crc5
    import axi_bm13xx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       init_i,
    input  logic       en_i,
    input  logic       last_i,
    input  logic [7:0] data_i,
    output logic [4:0] crc_o
);

    logic [4:0] crc_q, crc_d;

    always_comb begin
        crc_d = init_i ? CRC5_INIT : crc_q;
        if (en_i) begin
            for (int i = 7; i >= 0; i--) begin
                if (!last_i || i >= 5) begin
                    crc_d = crc5_step(crc_d, data_i[i]);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC5_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/bm13xx_work_rx_parser.sv
// BM13xx response frame parser feeding the Work/Command RX FIFOs with 2-word records.
// Optional BM13XX_RX_DROP_CNT_EN adds drop_cnt and moves FIFO-overflow drops off err_cnt.
module bm13xx_work_rx_parser
    import axi_bm13xx_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned ERR_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 bm139x,
    input  logic                 err_cnt_clear,
    input  logic [TIMEOUT_W-1:0] timeout_cyc,
    bm13xx_work_rx_parser_if.master bus,
`ifdef BM13XX_RX_DROP_CNT_EN
    output logic [15:0]          drop_cnt,
`endif
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN_BM138X - 1);

    col_state_e           col_q, col_d;
    push_state_e          push_q, push_d;
    logic [2:0]           idx_q, idx_d;
    logic [6:0][7:0]      frame_q, frame_d;
    logic [6:0][7:0]      hold_q, hold_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [31:0]          work_data_q, work_data_d, cmd_data_q, cmd_data_d;
    logic                 work_wr_q, work_wr_d, cmd_wr_q, cmd_wr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic       crc_init, crc_en, crc_last;
    logic [4:0] crc_val;
    logic       tmo_hit, pre_err, tmo_err, crc_err, ovf_err, frame_ok, err_inc;
    logic       frame_work, frame_afull, hold_work;
    logic [31:0] word0, word1;

    bm13xx_crc5 u_crc5 (
        .clk_i  (clk),
        .rst_i  (rst),
        .init_i (crc_init),
        .en_i   (crc_en),
        .last_i (crc_last),
        .data_i (bus.rx_data),
        .crc_o  (crc_val)
    );

    assign tmo_hit = (timeout_cyc != '0) && (tmo_q == timeout_cyc);

    always_comb begin
        col_d    = col_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        tmo_d    = '0;
        crc_init = 1'b1;
        crc_en   = 1'b0;
        crc_last = 1'b0;
        pre_err  = 1'b0;
        tmo_err  = 1'b0;
        crc_err  = 1'b0;
        frame_ok = 1'b0;
        unique case (col_q)
            ColPre1: begin
                tmo_d = tmo_q + 1'b1;
                if (bus.rx_valid) begin
                    tmo_d = '0;
                    if (bus.rx_data == PREAMBLE_1) begin
                        col_d = ColBody;
                        idx_d = '0;
                    end else if (bus.rx_data != PREAMBLE_0) begin
                        col_d   = ColIdle;
                        pre_err = 1'b1;
                    end
                end else if (tmo_hit) begin
                    col_d   = ColIdle;
                    tmo_err = 1'b1;
                end
            end
            ColBody: begin
                crc_init = 1'b0;
                tmo_d    = tmo_q + 1'b1;
                if (bus.rx_valid) begin
                    tmo_d          = '0;
                    frame_d[idx_q] = bus.rx_data;
                    crc_en         = 1'b1;
                    crc_last       = (idx_q == LAST_IDX);
                    if (idx_q == LAST_IDX) begin
                        col_d = ColCheck;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (tmo_hit) begin
                    col_d   = ColIdle;
                    tmo_err = 1'b1;
                end
            end
            ColCheck: begin
                frame_ok = (crc_val == frame_q[LAST_IDX][4:0]);
                crc_err  = !frame_ok;
                col_d    = ColIdle;
            end
            default: ;
        endcase
        // A byte landing in CHECK is the start of the next frame, handled as in IDLE
        if ((col_q == ColIdle || col_q == ColCheck) && bus.rx_valid) begin
            if (bm139x) begin
                if (bus.rx_data == PREAMBLE_0) begin
                    col_d = ColPre1;
                end
            end else begin
                frame_d[0] = bus.rx_data;
                crc_en     = 1'b1;
                idx_d      = 3'd1;
                col_d      = ColBody;
            end
        end
        if (!enable) begin
            col_d    = ColIdle;
            idx_d    = '0;
            tmo_d    = '0;
            pre_err  = 1'b0;
            tmo_err  = 1'b0;
            crc_err  = 1'b0;
            frame_ok = 1'b0;
        end
    end

    assign frame_work  = frame_q[LAST_IDX][TYPE_BIT];
    assign frame_afull = frame_work ? bus.work_afull : bus.cmd_afull;
    assign hold_work   = hold_q[LAST_IDX][TYPE_BIT];
    assign word0       = {hold_q[0], hold_q[1], hold_q[2], hold_q[3]};
    assign word1       = {8'h00, hold_q[6], hold_q[4], hold_q[5]};

    always_comb begin
        push_d      = push_q;
        hold_d      = hold_q;
        work_wr_d   = 1'b0;
        cmd_wr_d    = 1'b0;
        work_data_d = work_data_q;
        cmd_data_d  = cmd_data_q;
        ovf_err     = 1'b0;
        unique case (push_q)
            PushW0, PushW1: begin
                work_wr_d = hold_work;
                cmd_wr_d  = !hold_work;
                if (hold_work) begin
                    work_data_d = (push_q == PushW0) ? word0 : word1;
                end else begin
                    cmd_data_d = (push_q == PushW0) ? word0 : word1;
                end
                push_d = (push_q == PushW0) ? PushW1 : PushIdle;
            end
            default: ;
        endcase
        if (frame_ok) begin
            if (push_q != PushIdle || frame_afull) begin
                ovf_err = 1'b1;
            end else begin
                hold_d = frame_q;
                push_d = PushW0;
            end
        end
        if (!enable) begin
            push_d    = PushIdle;
            work_wr_d = 1'b0;
            cmd_wr_d  = 1'b0;
        end
    end

`ifdef BM13XX_RX_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign err_inc = pre_err | tmo_err | crc_err;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (err_cnt_clear) begin
            drop_cnt_d = '0;
        end else if (ovf_err && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign err_inc = pre_err | tmo_err | crc_err | ovf_err;
`endif

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clear) begin
            err_cnt_d = '0;
        end else if (err_inc && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= ColIdle;
            push_q      <= PushIdle;
            idx_q       <= '0;
            frame_q     <= '0;
            hold_q      <= '0;
            tmo_q       <= '0;
            work_data_q <= '0;
            cmd_data_q  <= '0;
            work_wr_q   <= 1'b0;
            cmd_wr_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            col_q       <= col_d;
            push_q      <= push_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
            work_data_q <= work_data_d;
            cmd_data_q  <= cmd_data_d;
            work_wr_q   <= work_wr_d;
            cmd_wr_q    <= cmd_wr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.work_data = work_data_q;
    assign bus.work_wr   = work_wr_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.cmd_wr    = cmd_wr_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: doc/bm13xx_work_rx_parser.md
Name: bm13xx_work_rx_parser

Overview:
Frame parser directly upstream of the Work Receive FIFO (WORK_RX_FIFO, 0x2000) and Command Receive FIFO (CMD_RX_FIFO, 0x1000) of the AXI BM13xx core.
- Consumes the byte stream from the UART receiver attached to the hash-chip chain.
- Delimits response frames and checks CRC5.
- Routes work (nonce) responses and command (register-read) responses as 2-word records into the matching FIFO.
- Counts framing, CRC and overflow errors for ERR_COUNTER (0x0018).

Parameters:
TIMEOUT_W, 16, width of inter-byte timeout counter and timeout_cyc port
ERR_CNT_W, 32, width of error counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
enable  in  1  CTRL_ENABLE bit of CTRL_REG
bm139x  in  1  CTRL_BM139X bit; 1 = BM1391/BM1397 frame format
err_cnt_clear  in  1  one-cycle pulse from CTRL_ERR_CNT_CLEAR write
timeout_cyc  in  TIMEOUT_W  inter-byte timeout in clk cycles; 0 = disabled
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe per byte; no backpressure
work_data  out  32  Work RX FIFO write data
work_wr  out  1  Work RX FIFO write strobe
work_afull  in  1  Work RX FIFO has fewer than 2 free words
cmd_data  out  32  Command RX FIFO write data
cmd_wr  out  1  Command RX FIFO write strobe
cmd_afull  in  1  Command RX FIFO has fewer than 2 free words
err_cnt  out  ERR_CNT_W  saturating error counter

Behaviour:
- Reset values: work_wr=0, cmd_wr=0, work_data=0, cmd_data=0, err_cnt=0; both FSMs in IDLE.
- Frame, bm139x=0: 7 bytes B0..B6.
- Frame, bm139x=1: preamble 0xAA 0x55, then B0..B6.
- Frame fields:
  - B0..B3: payload, big-endian (B0 = MSB).
  - B4: chip/midstate byte.
  - B5: work/job ID or register address.
  - B6[7]: type, 1 = work, 0 = command.
  - B6[4:0]: CRC5.
- CRC5: polynomial x^5+x^2+1, init 5'b11111, MSB-first over B0..B5 then B6[7:5] (51 bits). It must equal B6[4:0].
- Collect FSM states: IDLE, PRE1 (139x only), BODY (byte index 0..6), CHECK.
  - IDLE: bm139x=1 waits for 0xAA and goes to PRE1; otherwise a byte goes to BODY with index 1.
  - PRE1: 0x55 goes to BODY; 0xAA stays in PRE1; any other byte goes to IDLE and err_cnt+1.
  - BODY: after B6 goes to CHECK.
  - CHECK: lasts 1 cycle.
    - CRC good: copy frame to holding register, raise push request, go to IDLE.
    - CRC bad: err_cnt+1, frame dropped.
- Timeout: in PRE1/BODY, an idle counter reloads on each rx_valid. When it reaches timeout_cyc (≠0), discard the partial frame, err_cnt+1, go to IDLE.
- Push FSM states: IDLE, W0, W1.
  - Request accepted only if the target FIFO's afull=0 at CHECK.
  - W0 writes {B0,B1,B2,B3}.
  - W1 writes {8'h00, B6, B4, B5}.
  - One word per cycle, consecutive cycles; target FIFO selected by B6[7].
- Target afull=1 at CHECK: frame dropped, overflow counted (see optional feature).
- A byte arriving during W0/W1 is collected normally; the holding register isolates the two FSMs.
- A frame completing while a push is in progress cannot occur (≥6 byte times between frames). If it does, it is dropped and counted.
- enable=0: both FSMs forced to IDLE next cycle, partial frame and pending push discarded, no writes. err_cnt is retained.
- err_cnt saturates at all-ones. When err_cnt_clear and an increment coincide, the clear wins and the result is 0.
- Multiple error events in one cycle increment by 1.

Optional Feature:
BM13XX_RX_DROP_CNT_EN:
- Defined: adds output drop_cnt[15:0] (saturating, reset 0, cleared by err_cnt_clear). FIFO-overflow drops increment drop_cnt only.
- Undefined: no drop_cnt port; overflow drops increment err_cnt.

Decomposition:
- Shared package axi_bm13xx_pkg gains:
  - frame lengths (FRAME_LEN_BM138X=7, FRAME_LEN_BM139X=9)
  - preamble constants 8'hAA, 8'h55
  - CRC5 polynomial/init constants
  - type-bit index
  - a CRC5 step function
- One sub-module, bm13xx_crc5: bytewise serial CRC5 with init/enable/data and a 3-bit final-step mode.

Test Plan:
1. bm139x=0: send 12 34 56 78 01 2A plus B6 = {1, 2'b00, correct CRC} → work_wr twice: 0x12345678, then 0x00XX012A (XX = B6); err_cnt=0.
2. Same frame with B3 = 0x79 → no write, err_cnt=1; a following good frame is accepted normally.
3. bm139x=1: bytes AA AA 55 + 7-byte command frame (B6[7]=0) → preamble resync, cmd_wr of 2 words, work_wr=0.
4. timeout_cyc=100: send 4 bytes, idle 101 cycles, then a full good frame → err_cnt=1, exactly one 2-word record written.
5. work_afull=1 during CHECK → no write. drop_cnt=1 with macro; err_cnt=1 without.
6. err_cnt preset to all-ones via 2^32 errors (forced), one more error → stays all-ones; err_cnt_clear coinciding with an error → 0. enable dropped mid-frame → no writes, FSM restarts cleanly.
